image_stream_source: RTL and testbench
======================================

// Module: image_stream_source
// PURPOSE
// - Streams one stored RGB444 image from a synchronous ROM as an Avalon-ST video packet.
// - Sits directly upstream of the brightness filter.
// - Output is 12-bit {R[11:8],G[7:4],B[3:0]} with sop/eop/valid; ready from downstream is honoured.
// - Pixel order is raster: row 0 left to right, then row 1, and so on.
// PARAMETERS
// - WIDTH   320  pixels per line
// - HEIGHT  240  lines per frame
// - DATA_W  12   pixel width
// - ADDR_W  17   ROM address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
// PORTS
// - clk         in   1       system clock; all logic is on its rising edge
// - reset       in   1       synchronous, active-low reset
// - start       in   1       one-cycle pulse; begins a frame when idle
// - rom_addr    out  ADDR_W  ROM read address
// - rom_rd      out  1       ROM read strobe
// - rom_data    in   DATA_W  ROM data; valid exactly 1 clk after rom_rd
// - ready_in    in   1       backpressure from downstream
// - data_out    out  DATA_W  pixel
// - sop_out     out  1       first pixel of the frame
// - eop_out     out  1       last pixel of the frame
// - valid_out   out  1       data_out, sop_out and eop_out are valid
// - busy        out  1       a frame is in progress
// - frame_done  out  1       one-cycle pulse after the eop beat is accepted
// BEHAVIOUR
// - Reset (reset==0 at a clk edge):
//   - All outputs go to 0: valid, sop, eop, data, rom_addr, rom_rd, busy, frame_done.
//   - Skid FIFO is emptied and the FSM goes to IDLE.
//   - Reset mid-frame discards the frame; no eop is emitted.
// - Handshake: a beat transfers when valid_out && ready_in (ready latency 0).
//   - While ready_in==0, data_out, sop_out, eop_out and valid_out hold stable.
// - FSM:
//   - IDLE -> STREAM on start. Clear the issue counter and accept counter; busy=1.
//   - STREAM -> DRAIN when the last address (WIDTH*HEIGHT-1) has been issued.
//   - DRAIN -> IDLE when the eop beat is accepted. frame_done=1 for 1 clk; busy=0 on the same cycle.
//   - start is ignored outside IDLE.
// - Read issue:
//   - 2-entry skid FIFO; in_flight = rom_rd registered by 1 clk.
//   - Issue a read (rom_rd=1, rom_addr=issue_cnt, then issue_cnt++) only if fifo_count + in_flight < 2.
//   - Issue and pop in the same cycle are permitted; the count stays consistent.
//   - ROM return is written to the FIFO 1 clk after rom_rd. It never overflows.
//   - The FIFO head drives data_out; valid_out = FIFO non-empty.
// - Flags and counters:
//   - sop_out = (accept_cnt==0); eop_out = (accept_cnt==WIDTH*HEIGHT-1). Both are qualified by valid_out.
//   - accept_cnt increments per accepted beat and saturates at the last pixel. No wrap inside a frame.
// - Latency: start at cycle 0; rom_rd at 1; first valid_out at 3.
// - Throughput: 1 pixel/clk while ready_in stays high.
// - Simultaneous eop accept and start: start is ignored because the FSM is not yet IDLE.
// CONFIGURATION
// - FRAME_LOOP_EN defined:
//   - Accepting eop sends DRAIN -> STREAM directly, with counters cleared; busy stays 1.
//   - frame_done pulses every frame.
//   - The next sop beat may follow eop with no idle cycle.
//   - The FSM returns to IDLE only on reset.
// - FRAME_LOOP_EN undefined: one frame per start pulse, as described above.
// TESTING (bench uses WIDTH=4, HEIGHT=2, ROM[i]=12'h100+i)
// - Reset then start, ready_in=1 -> 8 beats 12'h100..12'h107 on consecutive clks.
//   - sop on 12'h100 only, eop on 12'h107 only.
//   - frame_done 1 clk after the 12'h107 beat; busy 0 on the same cycle.
// - ready_in low for 5 clks while beat 12'h102 is presented -> data_out holds 12'h102 with valid=1.
//   - rom_rd stalls after at most 2 outstanding entries.
//   - No beat is lost or duplicated.
// - ready_in toggled 1/0 every clk -> all 8 values accepted in order; 8 accepted beats in 15 clks.
// - start pulsed again at beat 12'h104 -> ignored; exactly one eop; exactly one frame_done.
// - reset=0 for 1 clk at beat 12'h103 -> next clk all outputs 0, busy=0.
//   - A fresh start then restarts at 12'h100 with sop.
// - FRAME_LOOP_EN, 2 frames -> 12'h107 (eop) is followed next clk by 12'h100 (sop).
//   - frame_done pulses twice; busy never drops.

Source files
------------

// File: rtl/image_stream_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : image_stream_source                                       |
// | Purpose  : Streams one stored RGB444 image from a synchronous ROM as |
// |            an Avalon-ST video packet (sop/eop/valid, ready latency 0)|
// |            in raster order, through a 2-entry skid FIFO.             |
// | Options  : define FRAME_LOOP_EN to stream frames back to back until  |
// |            reset instead of one frame per start pulse.               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module image_stream_source #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              ready_in,
  output logic [DATA_W-1:0] data_out,
  output logic              sop_out,
  output logic              eop_out,
  output logic              valid_out,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(WIDTH * HEIGHT - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

`ifdef FRAME_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] accept_cnt_q, accept_cnt_d;
  logic              in_flight_q, in_flight_d;
  logic [DATA_W-1:0] fifo_mem_q [2];
  logic [DATA_W-1:0] fifo_mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        fifo_count_q, fifo_count_d;
  logic              frame_done_q, frame_done_d;

  logic              fifo_valid;
  logic              beat_accept;
  logic              at_last_pix;
  logic              eop_accept;
  logic [2:0]        occupancy;
  logic              issue_phase;
  logic              issue_ok;
  logic              last_issue;
  logic              start_frame;

  // Handshake, credit accounting and read-issue decision.
  // The beat leaving the FIFO this cycle frees its slot in the same cycle,
  // which is what sustains one pixel per clock with only two entries.
  always_comb begin
    fifo_valid  = (fifo_count_q != 2'd0);
    beat_accept = fifo_valid && ready_in;
    at_last_pix = (accept_cnt_q == LAST_PIX);
    eop_accept  = beat_accept && at_last_pix;
    occupancy   = 3'(fifo_count_q) + 3'(in_flight_q) - 3'(beat_accept);
    // In loop mode the next frame's reads are prefetched while the tail of
    // the current frame drains, so eop can be followed directly by sop.
    issue_phase = (state_q == ST_STREAM) || (LOOP_EN && (state_q == ST_DRAIN));
    issue_ok    = issue_phase && (occupancy < 3'd2);
    last_issue  = issue_ok && (issue_cnt_q == LAST_PIX);
    start_frame = (state_q == ST_IDLE) && start;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start)      state_d = ST_STREAM;
      ST_STREAM: if (last_issue) state_d = ST_DRAIN;
      ST_DRAIN:  if (eop_accept) state_d = LOOP_EN ? ST_STREAM : ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath outputs.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    rom_rd     = issue_ok;
    rom_addr   = issue_cnt_q;
    valid_out  = fifo_valid;
    data_out   = fifo_valid ? fifo_mem_q[rd_ptr_q] : '0;
    sop_out    = fifo_valid && (accept_cnt_q == '0);
    eop_out    = fifo_valid && at_last_pix;
    frame_done = frame_done_q;
  end

  // Issue/accept counters; issue wraps only when frames loop, accept saturates
  // on the last pixel and restarts with the next frame.
  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    if (start_frame) begin
      issue_cnt_d  = '0;
      accept_cnt_d = '0;
    end else begin
      if (issue_ok) begin
        issue_cnt_d = (LOOP_EN && last_issue) ? '0 : issue_cnt_q + ADDR_W'(1);
      end
      if (beat_accept) begin
        if (at_last_pix) begin
          accept_cnt_d = LOOP_EN ? '0 : accept_cnt_q;
        end else begin
          accept_cnt_d = accept_cnt_q + ADDR_W'(1);
        end
      end
    end
    frame_done_d = eop_accept;
    in_flight_d  = issue_ok;
  end

  // Skid FIFO: ROM data lands one clock after its read strobe.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    if (in_flight_q) begin
      fifo_mem_d[wr_ptr_q] = rom_data;
    end
    wr_ptr_d     = wr_ptr_q ^ in_flight_q;
    rd_ptr_d     = rd_ptr_q ^ beat_accept;
    fifo_count_d = fifo_count_q + {1'b0, in_flight_q} - {1'b0, beat_accept};
  end

  // Datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_cnt_q   <= '0;
      accept_cnt_q  <= '0;
      in_flight_q   <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_count_q  <= 2'd0;
      frame_done_q  <= 1'b0;
    end else begin
      issue_cnt_q   <= issue_cnt_d;
      accept_cnt_q  <= accept_cnt_d;
      in_flight_q   <= in_flight_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      frame_done_q  <= frame_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_stream_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_image_stream_source                                    |
// | Purpose  : Self-checking bench for image_stream_source on a 4x2      |
// |            image with ROM[i] = 12'h100 + i. Build with FRAME_LOOP_EN |
// |            defined to exercise the looping variant.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_image_stream_source;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

`ifdef FRAME_LOOP_EN
  localparam logic LOOP_EN = 1'b1;
`else
  localparam logic LOOP_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] rom_addr;
  logic        rom_rd;
  logic [11:0] rom_data;
  logic        ready_in;
  logic [11:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        valid_out;
  logic        busy;
  logic        frame_done;

  image_stream_source #(.WIDTH(W), .HEIGHT(H), .DATA_W(12), .ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
    .ready_in(ready_in), .data_out(data_out), .sop_out(sop_out),
    .eop_out(eop_out), .valid_out(valid_out), .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: ROM[i] = 12'h100 + i, data one clock after the strobe.
  always_ff @(posedge clk) begin
    if (rom_rd) rom_data <= 12'h100 + rom_addr[11:0];
  end

  int checks = 0;
  int errors = 0;

  // Reference model of the stream, kept as counts of transactions.
  logic        m_zero, m_busy, m_fd;
  int          issued, accepted, exp_idx;
  int          cyc, first_acc, last_acc, fd_cnt, eop_cnt;
  logic        p_valid, p_ready, p_sop, p_eop;
  logic [11:0] p_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    logic busy_now;
    cyc++;
    if (m_zero) begin
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_data", 32'(data_out), 0);
      chk("rst_sop", 32'(sop_out), 0);
      chk("rst_eop", 32'(eop_out), 0);
      chk("rst_rom_rd", 32'(rom_rd), 0);
      chk("rst_rom_addr", 32'(rom_addr), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
    end
    m_zero = 1'b0;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done === 1'b1) fd_cnt++;
    m_fd = 1'b0;
    chk("outstanding_le_2", 32'((issued - accepted) <= 2), 1);
    if (rom_rd === 1'b1) begin
      chk("rom_addr_order", 32'(rom_addr), 32'(issued % NPIX));
      issued++;
    end
    if (p_valid && !p_ready) begin
      chk("hold_valid", 32'(valid_out), 1);
      chk("hold_data", 32'(data_out), 32'(p_data));
      chk("hold_sop", 32'(sop_out), 32'(p_sop));
      chk("hold_eop", 32'(eop_out), 32'(p_eop));
    end
    if (valid_out === 1'b1) begin
      chk("beat_data", 32'(data_out), 32'(12'h100 + exp_idx));
      chk("beat_sop", 32'(sop_out), 32'(exp_idx == 0));
      chk("beat_eop", 32'(eop_out), 32'(exp_idx == NPIX - 1));
    end
    p_valid  = valid_out;
    p_ready  = ready_in;
    p_data   = data_out;
    p_sop    = sop_out;
    p_eop    = eop_out;
    busy_now = m_busy;
    if (valid_out && ready_in) begin
      accepted++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (exp_idx == NPIX - 1) begin
        eop_cnt++;
        m_fd   = 1'b1;
        m_busy = LOOP_EN;
      end
      exp_idx = (exp_idx + 1) % NPIX;
    end
    if (start && !busy_now) begin
      m_busy   = 1'b1;
      issued   = 0;
      accepted = 0;
      exp_idx  = 0;
    end
    if (!reset) begin
      m_zero = 1'b1; m_busy = 1'b0; m_fd = 1'b0;
      issued = 0; accepted = 0; exp_idx = 0; p_valid = 1'b0;
    end
  endtask

  // One clock: drive inputs just after the falling edge, then check.
  task automatic cycle(input logic st, input logic rdy, input logic rstn);
    @(negedge clk);
    start    = st;
    ready_in = rdy;
    reset    = rstn;
    #2;
    model_step();
  endtask

  task automatic run_frames(input int nframes, input int mode, input int budget);
    int   target;
    int   n;
    logic r;
    logic s;
    target = fd_cnt + nframes;
    n = 0;
    while (fd_cnt < target && n < budget) begin
      r = (mode == 0) ? 1'b1 : logic'($urandom_range(0, 1));
      s = (mode == 0) ? 1'b0 : logic'($urandom_range(0, 15) == 0);
      cycle(s, r, 1'b1);
      n++;
    end
    chk("frame_timeout", 32'(fd_cnt >= target), 1);
  endtask

  task automatic run_until_data(input logic [11:0] d, input int budget);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b1, 1'b1);
      n++;
    end while (!(valid_out === 1'b1 && data_out === d) && n < budget);
    chk("wait_for_beat", 32'(data_out), 32'(d));
  endtask

  typedef struct {
    logic        st;
    logic        rdy;
    logic        e_valid;
    logic [11:0] e_data;
    logic        e_sop;
    logic        e_eop;
    logic        e_busy;
    logic        e_fd;
    logic        e_rd;
    logic [16:0] e_addr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int   eop0, fd0, n;
    logic r, b2b;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd1};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 12'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 12'h101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 12'h102, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd4};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 12'h103, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd5};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 12'h104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd6};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 12'h105, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 17'd7};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 12'h106, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 17'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 12'h107, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'd0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 17'd0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd0};

    m_zero = 1'b1; m_busy = 1'b0; m_fd = 1'b0;
    issued = 0; accepted = 0; exp_idx = 0;
    cyc = 0; first_acc = -1; last_acc = -1; fd_cnt = 0; eop_cnt = 0;
    p_valid = 1'b0; p_ready = 1'b0; p_sop = 1'b0; p_eop = 1'b0; p_data = '0;

    start = 1'b0; ready_in = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b0, 1'b1);  // reset state check

`ifndef FRAME_LOOP_EN
    // Cycle-exact first frame with ready held high.
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].st, vecs[i].rdy, 1'b1);
      chk("tbl_valid", 32'(valid_out), 32'(vecs[i].e_valid));
      if (vecs[i].e_valid) begin
        chk("tbl_data", 32'(data_out), 32'(vecs[i].e_data));
        chk("tbl_sop", 32'(sop_out), 32'(vecs[i].e_sop));
        chk("tbl_eop", 32'(eop_out), 32'(vecs[i].e_eop));
      end
      chk("tbl_busy", 32'(busy), 32'(vecs[i].e_busy));
      chk("tbl_frame_done", 32'(frame_done), 32'(vecs[i].e_fd));
      chk("tbl_rom_rd", 32'(rom_rd), 32'(vecs[i].e_rd));
      if (vecs[i].e_rd) chk("tbl_rom_addr", 32'(rom_addr), 32'(vecs[i].e_addr));
    end
    chk("frame1_eops", 32'(eop_cnt), 1);
    chk("frame1_done", 32'(fd_cnt), 1);

    // Backpressure for 5 clocks while 12'h102 is presented.
    eop0 = eop_cnt;
    cycle(1'b1, 1'b1, 1'b1);
    run_until_data(12'h101, 20);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("stall_data", 32'(data_out), 32'h102);
      chk("stall_valid", 32'(valid_out), 1);
      if (i >= 2) chk("stall_rom_rd", 32'(rom_rd), 0);
    end
    run_frames(1, 0, 50);
    chk("stall_beats", 32'(accepted), 8);
    chk("stall_eops", 32'(eop_cnt - eop0), 1);

    // ready toggling every clock: 8 beats over 15 clocks.
    first_acc = -1;
    cycle(1'b1, 1'b0, 1'b1);
    n = 0;
    while (valid_out !== 1'b1 && n < 10) begin
      cycle(1'b0, 1'b0, 1'b1);
      n++;
    end
    r = 1'b1;
    fd0 = fd_cnt;
    n = 0;
    while (fd_cnt == fd0 && n < 40) begin
      cycle(1'b0, r, 1'b1);
      r = ~r;
      n++;
    end
    chk("toggle_beats", 32'(accepted), 8);
    chk("toggle_span", 32'(last_acc - first_acc + 1), 15);

    // Second start pulse mid-frame is ignored.
    eop0 = eop_cnt;
    fd0  = fd_cnt;
    cycle(1'b1, 1'b1, 1'b1);
    run_until_data(12'h103, 20);
    cycle(1'b1, 1'b1, 1'b1);
    chk("restart_ignored_data", 32'(data_out), 32'h104);
    run_frames(1, 0, 50);
    repeat (6) cycle(1'b0, 1'b1, 1'b1);
    chk("restart_one_eop", 32'(eop_cnt - eop0), 1);
    chk("restart_one_done", 32'(fd_cnt - fd0), 1);

    // Reset mid-frame at beat 12'h103, then a fresh frame.
    eop0 = eop_cnt;
    cycle(1'b1, 1'b1, 1'b1);
    run_until_data(12'h102, 20);
    cycle(1'b0, 1'b1, 1'b0);
    chk("reset_at_beat", 32'(data_out), 32'h103);
    cycle(1'b0, 1'b1, 1'b1);
    chk("reset_no_eop", 32'(eop_cnt - eop0), 0);
    cycle(1'b1, 1'b1, 1'b1);
    run_frames(1, 0, 50);
    chk("after_reset_beats", 32'(accepted), 8);

    // Randomised backpressure and stray start pulses.
    for (int f = 0; f < 4; f++) begin
      cycle(1'b1, logic'($urandom_range(0, 1)), 1'b1);
      run_frames(1, 1, 300);
      chk("rand_beats", 32'(accepted), 8);
    end
`else
    // Looping frames: eop beat followed directly by the next sop beat.
    cycle(1'b1, 1'b1, 1'b1);
    b2b = 1'b0;
    n = 0;
    while (fd_cnt < 2 && n < 60) begin
      cycle(1'b0, 1'b1, 1'b1);
      if (b2b) begin
        chk("loop_next_valid", 32'(valid_out), 1);
        chk("loop_next_data", 32'(data_out), 32'h100);
        chk("loop_next_sop", 32'(sop_out), 1);
      end
      b2b = valid_out && ready_in && eop_out;
      chk("loop_busy_held", 32'(busy), 1);
      n++;
    end
    chk("loop_two_done", 32'(fd_cnt), 2);
    chk("loop_two_eop", 32'(eop_cnt), 2);

    // Randomised backpressure across further frames.
    run_frames(3, 1, 400);
    chk("loop_busy_end", 32'(busy), 1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    chk("loop_reset_idle", 32'(busy), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
